// File: rtl/rr_dec_arbiter_pkg.sv
// Shared definitions for the round-robin decoded-grant arbiter.
package rr_dec_arbiter_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_dec_arbiter_dec.sv
// 3-to-8 one-hot decoder, purely combinational.
module onehot_dec3to8
  import rr_dec_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0] sel,
  output logic [NREQ-1:0]  dec
);

  // Set exactly one output bit selected by the index.
  always_comb begin
    dec      = '0;
    dec[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter for 8 requesters with hold limit and inter-grant gap.
// The grant is kept as an index and decoded to a registered one-hot vector.
module rr_dec_arbiter
  import rr_dec_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 8
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_valid,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [CNT_W-1:0]  hold_cnt, hold_nxt;
  logic [CNT_W-1:0]  gap_cnt, gap_nxt;
  logic [NREQ-1:0]   gnt_nxt, dec_out;
  logic [NREQ-1:0]   req_ok;
  logic [IDX_W:0]    search;
  logic              own_nxt, to_nxt, lim_hit, req_drop;

  // First requester at or after p, ascending with wrap; MSB flags a hit.
  function automatic logic [IDX_W:0] find_next(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic             found;
    logic [IDX_W-1:0] idx, cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      cand = p + IDX_W'(j);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // Only a definite 1 is a request; X/Z bits never win arbitration.
  always_comb begin
    req_ok = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      req_ok[i] = (req[i] === 1'b1);
  end

  assign search = find_next(req_ok, ptr);

  // Decoder sits on the next-index path so gnt comes straight from a flop.
  onehot_dec3to8 u_dec (
    .sel (idx_nxt),
    .dec (dec_out)
  );

  // Next-state, pointer, counter and grant computation.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    own_nxt   = 1'b0;
    to_nxt    = 1'b0;
    lim_hit   = 1'b0;
    req_drop  = 1'b0;
    case (state)
      IDLE: begin
        if (search[IDX_W]) begin
          idx_nxt   = search[IDX_W-1:0];
          hold_nxt  = CNT_W'(1);
          own_nxt   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        lim_hit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
        req_drop = !req_ok[gnt_idx];
        if (lim_hit || req_drop) begin
          ptr_nxt = gnt_idx + IDX_W'(1);
          to_nxt  = lim_hit && !req_drop;
          if (GAP_CYCLES != 0) begin
            state_nxt = GAP;
            gap_nxt   = CNT_W'(1);
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          own_nxt = 1'b1;
          if (hold_cnt != '1)
            hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LIM)
          state_nxt = IDLE;
        else
          gap_nxt = gap_cnt + CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    gnt_nxt = own_nxt ? dec_out : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt      <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_idx  <= idx_nxt;
      gnt      <= gnt_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
      timeout  <= to_nxt;
    end
  end

  assign gnt_valid = (gnt != '0);

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Directed bench for rr_dec_arbiter: three parameterisations share clk/reset/req.
module tb_rr_dec_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] req = '0;

  // a: defaults (MAX_HOLD=8, GAP=1); b: MAX_HOLD=4, GAP=1; c: MAX_HOLD=0, GAP=0
  logic [7:0] gnt_a, gnt_b, gnt_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       val_a, val_b, val_c;
  logic       to_a, to_b, to_c;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  rr_dec_arbiter u_a (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .timeout(to_a)
  );

  rr_dec_arbiter #(.MAX_HOLD(4), .GAP_CYCLES(1), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .timeout(to_b)
  );

  rr_dec_arbiter #(.MAX_HOLD(0), .GAP_CYCLES(0), .CNT_W(8)) u_c (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(val_c), .timeout(to_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // 1: reset holds everything low even with all requesting
    reset = 1'b0;
    req   = 8'hFF;
    tick();
    tick();
    check("rst_gnt",   32'(gnt_a), 32'h00);
    check("rst_valid", 32'(val_a), 32'h0);
    check("rst_to",    32'(to_a),  32'h0);
    check("rst_idx",   32'(idx_a), 32'h0);
    reset = 1'b1;
    tick();
    check("rel_gnt", 32'(gnt_a), 32'h01);
    check("rel_idx", 32'(idx_a), 32'h0);
    check("rel_val", 32'(val_a), 32'h1);

    // 2: single requester, latency 1, drop releases next edge, ptr moves to 3
    do_reset();
    req = 8'b0000_0100;
    tick();
    check("t2_gnt", 32'(gnt_a), 32'h04);
    check("t2_idx", 32'(idx_a), 32'h2);
    tick(); tick(); tick();
    check("t2_hold", 32'(gnt_a), 32'h04);
    req = 8'h00;
    tick();
    check("t2_drop_gnt", 32'(gnt_a), 32'h00);
    check("t2_drop_val", 32'(val_a), 32'h0);
    check("t2_drop_to",  32'(to_a),  32'h0);
    check("t2_idx_hold", 32'(idx_a), 32'h2);
    req = 8'h0C;
    tick();
    check("t2_gap", 32'(gnt_a), 32'h00);
    tick();
    check("t2_ptr3", 32'(gnt_a), 32'h08);

    // 3: MAX_HOLD=4, everyone requesting: 4 on, timeout, 2 off, next owner
    do_reset();
    req = 8'hFF;
    tick();
    for (int o = 0; o < 9; o++) begin
      for (int c = 0; c < 4; c++) begin
        check("t3_on",  32'(gnt_b), 32'h1 << (o % 8));
        check("t3_to0", 32'(to_b),  32'h0);
        tick();
      end
      check("t3_off1", 32'(gnt_b), 32'h00);
      check("t3_to1",  32'(to_b),  32'h1);
      check("t3_idx",  32'(idx_b), 32'(o % 8));
      tick();
      check("t3_off2", 32'(gnt_b), 32'h00);
      check("t3_to2",  32'(to_b),  32'h0);
      tick();
    end

    // 4: wrap 7 -> 0, then 0 -> 7, with MAX_HOLD=8 timeouts
    do_reset();
    req = 8'h80;
    tick();
    check("t4_g7", 32'(gnt_a), 32'h80);
    req = 8'h81;
    for (int i = 0; i < 7; i++) tick();
    check("t4_g7_last", 32'(gnt_a), 32'h80);
    tick();
    check("t4_rel7", 32'(gnt_a), 32'h00);
    check("t4_to7",  32'(to_a),  32'h1);
    tick();
    tick();
    check("t4_wrap0", 32'(gnt_a), 32'h01);
    for (int i = 0; i < 8; i++) tick();
    check("t4_rel0", 32'(gnt_a), 32'h00);
    check("t4_to0",  32'(to_a),  32'h1);
    tick();
    tick();
    check("t4_g7b",  32'(gnt_a), 32'h80);
    check("t4_idx7", 32'(idx_a), 32'h7);

    // 5: reset mid-grant clears grant and pointer
    do_reset();
    req = 8'h10;
    tick();
    check("t5_g4", 32'(gnt_a), 32'h10);
    req = 8'h20;
    tick();
    tick();
    tick();
    check("t5_g5", 32'(gnt_a), 32'h20);
    reset = 1'b0;
    req   = 8'h30;
    tick();
    check("t5_rst_gnt", 32'(gnt_a), 32'h00);
    check("t5_rst_idx", 32'(idx_a), 32'h0);
    check("t5_rst_val", 32'(val_a), 32'h0);
    reset = 1'b1;
    tick();
    check("t5_ptr0", 32'(gnt_a), 32'h10);

    // 6: unlimited hold, saturating counter, X request ignored, zero gap
    do_reset();
    req = 8'h02;
    tick();
    for (int i = 0; i < 300; i++) begin
      check("t6_hold", 32'(gnt_c), 32'h02);
      check("t6_to",   32'(to_c),  32'h0);
      tick();
    end
    req = 8'b0000_00x0;
    tick();
    check("t6_x_gnt", 32'(gnt_c), 32'h00);
    check("t6_x_val", 32'(val_c), 32'h0);
    check("t6_x_to",  32'(to_c),  32'h0);
    req = 8'h02;
    tick();
    check("t6_gap0", 32'(gnt_c), 32'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
